slice_mux: RTL

// - Encoder-side slice multiplexer. Per-slice chunk streams are interleaved into one
//   256-bit byte-packed output stream.
// - Emission order is slice 0, 1, ..., slices_per_line-1, then wraps to slice 0.
// - Each chunk is exactly chunk_size bytes. Chunks are packed back-to-back with no gaps.
// - Output byte i of a word is at bits [i*8+:8].

---
 rtl/slice_mux_pkg.sv | 25 ++
 rtl/slice_mux_byte_packer.sv | 56 +++++
 rtl/slice_mux.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/slice_mux_pkg.sv
// Shared constants, FSM state encodings and byte-mask helper for the slice multiplexer.
package slice_mux_pkg;

    localparam int BUS_BYTES = 32;
    localparam int BUS_W     = 256;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Mask keeping the low nbytes bytes of a bus word.
    function automatic logic [BUS_W-1:0] byte_mask(input logic [5:0] nbytes);
        logic [BUS_W-1:0] m;
        m = {BUS_W{1'b0}};
        for (int i = 0; i < BUS_BYTES; i++) begin
            if (6'(i) < nbytes) begin
                m[i*8 +: 8] = 8'hFF;
            end else begin
                m[i*8 +: 8] = 8'h00;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/slice_mux_byte_packer.sv
// Two-word byte accumulator: pops one full word from the bottom, then appends a
// variable number of bytes right above the bytes still held.
module slice_mux_byte_packer
    import slice_mux_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             pop_i,
    input  logic             push_i,
    input  logic [BUS_W-1:0] push_data_i,
    input  logic [5:0]       push_bytes_i,
    output logic [BUS_W-1:0] word_o,
    output logic [5:0]       cnt_o
);

    logic [2*BUS_W-1:0] acc_q, acc_d, acc_pop_s, push_ext_s;
    logic [5:0]         cnt_q, cnt_d, cnt_pop_s;

    // Pop then append; bytes above cnt are kept zero so a partial word pads with zeros.
    always_comb begin
        if (pop_i) begin
            acc_pop_s = acc_q >> BUS_W;
            cnt_pop_s = (cnt_q >= 6'd32) ? (cnt_q - 6'd32) : 6'd0;
        end else begin
            acc_pop_s = acc_q;
            cnt_pop_s = cnt_q;
        end
        push_ext_s = {{BUS_W{1'b0}}, push_data_i & byte_mask(push_bytes_i)} << {cnt_pop_s, 3'b000};
        if (clr_i) begin
            acc_d = {(2*BUS_W){1'b0}};
            cnt_d = 6'd0;
        end else if (push_i) begin
            acc_d = acc_pop_s | push_ext_s;
            cnt_d = cnt_pop_s + push_bytes_i;
        end else begin
            acc_d = acc_pop_s;
            cnt_d = cnt_pop_s;
        end
    end

    // Accumulator state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= {(2*BUS_W){1'b0}};
            cnt_q <= 6'd0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign word_o = acc_q[BUS_W-1:0];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/slice_mux.sv
// Encoder-side slice multiplexer: interleaves per-slice chunk streams, one chunk
// per slice in round-robin order, into a single byte-packed 256-bit stream.
module slice_mux
    import slice_mux_pkg::*;
#(
    parameter int MAX_NBR_SLICES  = 2,
    parameter int MAX_SLICE_WIDTH = 2560
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [9:0]                    slices_per_line,
    input  logic [15:0]                   chunk_size,
    input  logic                          in_sof,
    input  logic [BUS_W*MAX_NBR_SLICES-1:0] in_data_p,
    input  logic [MAX_NBR_SLICES-1:0]     in_valid,
    output logic [MAX_NBR_SLICES-1:0]     in_ready,
    output logic [BUS_W-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sof
);

    localparam int SLICE_W = (MAX_NBR_SLICES > 1) ? $clog2(MAX_NBR_SLICES) : 1;

    logic [1:0]         state_q, state_d;
    logic [9:0]         spl_q, spl_d;
    logic [15:0]        csz_q, csz_d;
    logic [SLICE_W-1:0] slice_q, slice_d;
    logic [11:0]        wcnt_q, wcnt_d;
    logic               sof_pend_q, sof_pend_d;

    logic [5:0]         acc_cnt_s, last_bytes_s, push_bytes_s;
    logic [BUS_W-1:0]   acc_word_s, sel_data_s;
    logic [11:0]        words_s;
    logic [6:0]         cnt_after_pop_s;
    logic [9:0]         slice_next_s;
    logic               running_s, flushing_s, out_fire_s, in_fire_s;
    logic               ready_s, sel_valid_s, last_s;

    // Output side, input selection and ready decode.
    always_comb begin
        running_s  = (state_q == ST_RUN);
        flushing_s = (state_q == ST_FLUSH);
        // While flushing, a partial residue word is also emitted.
        out_valid  = (running_s & (acc_cnt_s >= 6'd32)) | (flushing_s & (acc_cnt_s != 6'd0));
        out_fire_s = out_valid & out_ready;
        out_sof    = sof_pend_q & out_valid;
        out_data   = acc_word_s;

        cnt_after_pop_s = {1'b0, acc_cnt_s} - (out_fire_s ? 7'd32 : 7'd0);
        ready_s         = running_s & (cnt_after_pop_s < 7'd32);

        sel_data_s  = {BUS_W{1'b0}};
        sel_valid_s = 1'b0;
        for (int s = 0; s < MAX_NBR_SLICES; s++) begin
            in_ready[s] = ready_s & (slice_q == SLICE_W'(s));
            sel_data_s  = sel_data_s | (in_data_p[s*BUS_W +: BUS_W] & {BUS_W{slice_q == SLICE_W'(s)}});
            sel_valid_s = sel_valid_s | (in_valid[s] & (slice_q == SLICE_W'(s)));
        end
        in_fire_s = ready_s & sel_valid_s;

        words_s      = 12'((17'(csz_q) + 17'd31) >> 5);
        last_s       = (wcnt_q == (words_s - 12'd1));
        last_bytes_s = (csz_q[4:0] == 5'd0) ? 6'd32 : {1'b0, csz_q[4:0]};
        push_bytes_s = last_s ? last_bytes_s : 6'd32;
        slice_next_s = 10'(slice_q) + 10'd1;
    end

    // Frame FSM, slice/word counters and start-of-frame marker.
    always_comb begin
        state_d    = state_q;
        spl_d      = spl_q;
        csz_d      = csz_q;
        slice_d    = slice_q;
        wcnt_d     = wcnt_q;
        sof_pend_d = sof_pend_q;
        if (in_sof) begin
            state_d    = ST_RUN;
            spl_d      = slices_per_line;
            csz_d      = chunk_size;
            slice_d    = {SLICE_W{1'b0}};
            wcnt_d     = 12'd0;
            sof_pend_d = 1'b1;
        end else begin
            if (in_fire_s && last_s) begin
                wcnt_d  = 12'd0;
                slice_d = (slice_next_s >= spl_q) ? {SLICE_W{1'b0}} : slice_next_s[SLICE_W-1:0];
            end else if (in_fire_s) begin
                wcnt_d = wcnt_q + 12'd1;
            end else begin
                wcnt_d = wcnt_q;
            end
            if (out_fire_s) begin
                sof_pend_d = 1'b0;
            end else begin
                sof_pend_d = sof_pend_q;
            end
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_RUN:   state_d = flush ? ST_FLUSH : ST_RUN;
                ST_FLUSH: begin
                    if ((out_fire_s && (acc_cnt_s <= 6'd32)) || (acc_cnt_s == 6'd0)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            spl_q      <= 10'd0;
            csz_q      <= 16'd0;
            slice_q    <= {SLICE_W{1'b0}};
            wcnt_q     <= 12'd0;
            sof_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            spl_q      <= spl_d;
            csz_q      <= csz_d;
            slice_q    <= slice_d;
            wcnt_q     <= wcnt_d;
            sof_pend_q <= sof_pend_d;
        end
    end

    slice_mux_byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (in_sof),
        .pop_i        (out_fire_s),
        .push_i       (in_fire_s),
        .push_data_i  (sel_data_s),
        .push_bytes_i (push_bytes_s),
        .word_o       (acc_word_s),
        .cnt_o        (acc_cnt_s)
    );

endmodule
